hysteretic_range_classifier: RTL and testbench

//  Sequential successor to the combinational quartile classifier. Maps an N-bit

---
 rtl/hysteretic_range_classifier.sv | 101 ++++++++++
 tb/tb_hysteretic_range_classifier.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hysteretic_range_classifier.sv
// Quartile range classifier with hysteresis bands and a debounce counter.
// The committed class only moves after SETTLE consecutive qualifying valid samples.
module hysteretic_range_classifier #(
  parameter int N      = 8,
  parameter int HYST   = 4,
  parameter int SETTLE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] number,
  output logic [1:0]   out_bits,
  output logic         out_valid,
  output logic         changed
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [N:0] HYST_X = (N+1)'(HYST);
  localparam logic [N:0] MAX_X  = {1'b0, {N{1'b1}}};

  logic [1:0]    class_q, class_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;

  logic [N:0]    numX, sumX, lowX, highX;
  logic [1:0]    upClass, downClass, rawClass, target;
  logic [CW-1:0] bumped;

  // Saturating +/-HYST in N+1 bits so neither side wraps around.
  always_comb begin
    numX      = {1'b0, number};
    sumX      = numX + HYST_X;
    lowX      = (numX < HYST_X) ? '0 : (numX - HYST_X);
    highX     = (sumX > MAX_X) ? MAX_X : sumX;
    upClass   = 2'(lowX >> (N - 2));
    downClass = 2'(highX >> (N - 2));
    rawClass  = 2'(numX >> (N - 2));
    if (upClass > class_q) begin
      target = upClass;
    end else if (downClass < class_q) begin
      target = downClass;
    end else begin
      target = class_q;
    end
  end

  always_comb begin
    class_d   = class_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    cand_d    = cand_q;
    count_d   = count_q;
    bumped    = '0;
    if (in_valid) begin
      if (!valid_q) begin
        class_d   = rawClass;
        valid_d   = 1'b1;
        changed_d = 1'b1;
        cand_d    = rawClass;
        count_d   = '0;
      end else if (target == class_q) begin
        cand_d  = class_q;
        count_d = '0;
      end else begin
        // A new direction restarts the streak; the same one extends it.
        bumped = (target != cand_q) ? CW'(1) : (count_q + CW'(1));
        cand_d = target;
        if (bumped == CW'(SETTLE)) begin
          class_d   = target;
          count_d   = '0;
          changed_d = 1'b1;
        end else begin
          count_d = bumped;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      cand_q    <= '0;
      count_q   <= '0;
    end else begin
      class_q   <= class_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      cand_q    <= cand_d;
      count_q   <= count_d;
    end
  end

  assign out_bits  = class_q;
  assign out_valid = valid_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_hysteretic_range_classifier.sv
// Scoreboard bench: a reference model queues every expected commit, and a
// monitor pops one entry per observed changed pulse.
module tb_hysteretic_range_classifier;

  localparam int N      = 8;
  localparam int HYST   = 4;
  localparam int SETTLE = 3;
  localparam int Q      = 1 << (N - 2);
  localparam int MAXV   = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] number;
  logic [1:0]   out_bits;
  logic         out_valid;
  logic         changed;

  int assertCount = 0;
  int failCount   = 0;

  logic [1:0] expQ[$];

  // Reference model state: committed class, primed flag, pending target, streak.
  int mC     = 0;
  bit mValid = 0;
  int mCand  = 0;
  int mCnt   = 0;

  hysteretic_range_classifier #(.N(N), .HYST(HYST), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .number   (number),
    .out_bits (out_bits),
    .out_valid(out_valid),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int targetOf(input int x, input int c);
    int lo, hi, up, dn;
    lo = (x - HYST < 0) ? 0 : x - HYST;
    hi = (x + HYST > MAXV) ? MAXV : x + HYST;
    up = lo / Q;
    dn = hi / Q;
    if (up > c) return up;
    if (dn < c) return dn;
    return c;
  endfunction

  task automatic modelStep(input bit v, input int x);
    int t;
    if (!v) return;
    if (!mValid) begin
      mC = x / Q; mValid = 1; mCand = mC; mCnt = 0;
      expQ.push_back(2'(mC));
      return;
    end
    t = targetOf(x, mC);
    if (t == mC) begin
      mCand = mC; mCnt = 0;
    end else begin
      if (t != mCand) begin
        mCand = t; mCnt = 1;
      end else begin
        mCnt++;
      end
      if (mCnt == SETTLE) begin
        mC = t; mCnt = 0;
        expQ.push_back(2'(t));
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input int x);
    in_valid = v;
    number   = N'(x);
    modelStep(v, x);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input bit v, input int x);
    rst      = 1'b1;
    in_valid = v;
    number   = N'(x);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    mC = 0; mValid = 0; mCand = 0; mCnt = 0;
    checkOutput("resetOutBits", int'(out_bits), 0);
    checkOutput("resetOutValid", int'(out_valid), 0);
    checkOutput("resetChanged", int'(changed), 0);
  endtask

  task automatic checkSettled(input string name);
    @(negedge clk);
    #1;
    checkOutput({name, "_pendingCommits"}, expQ.size(), 0);
    checkOutput({name, "_outBits"}, int'(out_bits), mC);
    checkOutput({name, "_outValid"}, int'(out_valid), int'(mValid));
  endtask

  // Monitor: every changed pulse must match the oldest predicted commit.
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL spuriousChanged: got pulse with out_bits=%0d, expected no pulse at %0t",
                 out_bits, $time);
      end else begin
        logic [1:0] e;
        e = expQ.pop_front();
        checkOutput("commitClass", int'(out_bits), int'(e));
        checkOutput("commitValid", int'(out_valid), 1);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; number = '0;
    @(negedge clk);
    applyReset(1'b0, 0);

    // First sample commits directly.
    applyStimulus(1, 100);
    checkSettled("prime100");
    checkOutput("prime100_const", int'(out_bits), 1);

    // Jitter inside the band, then a real move to class 2.
    for (int i = 0; i < 5; i++) applyStimulus(1, 130);
    checkSettled("hold130");
    for (int i = 0; i < 3; i++) applyStimulus(1, 132);
    checkSettled("rise132");
    checkOutput("rise132_const", int'(out_bits), 2);

    // A sample back inside the band cancels the pending change.
    applyStimulus(1, 60); applyStimulus(1, 60); applyStimulus(1, 130);
    applyStimulus(1, 60); applyStimulus(1, 60);
    checkSettled("cancelled");
    checkOutput("cancelled_const", int'(out_bits), 2);
    applyStimulus(1, 60);
    checkSettled("fall60");
    checkOutput("fall60_const", int'(out_bits), 1);

    // Multi-class jumps at both saturation ends.
    applyReset(1'b0, 0);
    applyStimulus(1, 10);
    for (int i = 0; i < 3; i++) applyStimulus(1, 255);
    checkSettled("jumpUp");
    checkOutput("jumpUp_const", int'(out_bits), 3);
    for (int i = 0; i < 3; i++) applyStimulus(1, 2);
    checkSettled("jumpDown");
    checkOutput("jumpDown_const", int'(out_bits), 0);

    // Idle cycles neither count nor cancel.
    applyStimulus(1, 200); applyStimulus(0, 0); applyStimulus(0, 0);
    applyStimulus(1, 200); applyStimulus(0, 0); applyStimulus(1, 200);
    checkSettled("idleGaps");
    checkOutput("idleGaps_const", int'(out_bits), 3);

    // Reset mid-debounce, with in_valid asserted on the reset edge.
    applyReset(1'b0, 0);
    applyStimulus(1, 100);
    applyStimulus(1, 200); applyStimulus(1, 200);
    applyReset(1'b1, 200);
    applyStimulus(1, 30);
    checkSettled("reprime30");
    checkOutput("reprime30_const", int'(out_bits), 0);

    // Randomized traffic clustered around the class boundaries.
    for (int i = 0; i < 600; i++) begin
      int r, x;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, MAXV));
      end else begin
        x = Q * int'($urandom_range(1, 3)) + int'($urandom_range(0, 20)) - 10;
      end
      if (r < 2) begin
        applyReset(1'($urandom_range(0, 1)), x);
      end else begin
        applyStimulus(r < 75, x);
      end
      if (i % 60 == 59) checkSettled("random");
    end
    checkSettled("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
